// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with 1-cycle logic/arith ops and iterative MULTU/DIVU; in: i_clk i_rst_n i_valid i_control i_op1 i_op2, out: o_ready o_valid o_result o_zf o_hi o_dz
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [3:0]       i_control,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zf,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_dz
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
    OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_SLTU = 4'b1000, OP_MULTU = 4'b0011,
    OP_DIVU = 4'b0100, OP_MFHI = 4'b0101, OP_MFLO = 4'b1001;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, opb, rem, quo, alu, rem_nx, quo_nx;
  logic [2*WIDTH:0] p, p_nx;
  logic [WIDTH:0] psum, r_sh, diff;
  logic accept, last;
  assign o_ready = state == IDLE;
  assign o_hi = hi;
  assign accept = o_ready && i_valid;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    alu = i_control == OP_AND  ? i_op1 & i_op2 :
          i_control == OP_OR   ? i_op1 | i_op2 :
          i_control == OP_ADD  ? i_op1 + i_op2 :
          i_control == OP_SUB  ? i_op1 - i_op2 :
          i_control == OP_SLT  ? WIDTH'($signed(i_op1) < $signed(i_op2)) :
          i_control == OP_SLTU ? WIDTH'(i_op1 < i_op2) :
          i_control == OP_NOR  ? ~(i_op1 | i_op2) :
          i_control == OP_MFHI ? hi :
          i_control == OP_MFLO ? lo : '0;
    psum = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, opb} : '0);
    p_nx = {1'b0, psum, p[WIDTH-1:1]};
    r_sh = {rem, quo[WIDTH-1]};
    diff = r_sh - {1'b0, opb};
    rem_nx = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept)
      state_nx = i_control == OP_MULTU ? MUL : i_control == OP_DIVU ? DIV : IDLE;
    else if (state != IDLE && last)
      state_nx = IDLE;
  end
  always_ff @(posedge i_clk)
    state <= !i_rst_n ? IDLE : state_nx;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opb <= '0;
      rem <= '0;
      quo <= '0;
      p <= '0;
      o_result <= '0;
      o_zf <= 1'b1;
      o_valid <= 1'b0;
      o_dz <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_dz <= 1'b0;
      if (accept) begin
        cnt <= '0;
        opb <= i_op2;
        if (i_control == OP_MULTU) begin
          p <= {{(WIDTH + 1){1'b0}}, i_op1};
        end else if (i_control == OP_DIVU) begin
          rem <= '0;
          quo <= i_op1;
        end else begin
          o_result <= alu;
          o_zf <= alu == '0;
          o_valid <= 1'b1;
        end
      end
      if (state == MUL) begin
        p <= p_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi <= p_nx[2*WIDTH-1:WIDTH];
          lo <= p_nx[WIDTH-1:0];
          o_result <= p_nx[WIDTH-1:0];
          o_zf <= p_nx[WIDTH-1:0] == '0;
          o_valid <= 1'b1;
        end
      end
      if (state == DIV) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi <= rem_nx;
          lo <= quo_nx;
          o_result <= quo_nx;
          o_zf <= quo_nx == '0;
          o_dz <= opb == '0;
          o_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand, result, HI and LO width; legal values 8..64.
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  synchronous, active-low reset.
REQ-004 i_valid  input  1  operation request; accepted on a rising edge where i_valid=1 and o_ready=1.
REQ-005 i_control  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 SLTU, 0011 MULTU, 0100 DIVU, 0101 MFHI, 1001 MFLO.
REQ-006 i_op1, i_op2  input  WIDTH  operands; sampled only at the acceptance edge.
REQ-007 o_ready  output  1  high when a new request can be accepted.
REQ-008 o_valid  output  1  one-cycle pulse marking o_result, o_zf and o_dz as valid.
REQ-009 o_result  output  WIDTH  registered result.
REQ-010 o_zf  output  1  registered: 1 when o_result is all zeros.
REQ-011 o_hi  output  WIDTH  current HI register (product upper half / remainder).
REQ-012 o_dz  output  1  registered: 1 on the o_valid pulse of a DIVU with i_op2=0; 0 otherwise.

Function
REQ-013 FSM states: IDLE, MUL, DIV; o_ready=1 only in IDLE.
REQ-014 Single-cycle ops (AND, OR, ADD, SUB, SLT, SLTU, NOR, MFHI, MFLO) accepted in IDLE stay in IDLE; results register at the acceptance edge; o_valid=1 in the next cycle (latency 1).
REQ-015 ADD/SUB: modulo 2^WIDTH, carry/overflow discarded.
REQ-016 SLT: result 1 when i_op1 < i_op2 as two's-complement, else 0, zero-extended; SLTU: the same comparison, unsigned.
REQ-017 MFHI: o_result = HI; MFLO: o_result = LO; HI/LO unchanged.
REQ-018 Unlisted opcode: accepted as single-cycle; o_result=0, o_zf=1, HI/LO unchanged.
REQ-019 MULTU: IDLE->MUL at acceptance; unsigned shift-add, one bit per cycle, WIDTH iterations; then {HI,LO} = i_op1*i_op2 (2*WIDTH bits) and o_result = LO.
REQ-020 DIVU: IDLE->DIV at acceptance; unsigned restoring division, one bit per cycle, WIDTH iterations; then LO = quotient, HI = remainder, o_result = quotient.
REQ-021 DIVU with i_op2=0: full WIDTH-cycle latency; LO and o_result all ones, HI = i_op1, o_dz=1 with o_valid.
REQ-022 Multi-cycle latency: acceptance at edge E0; the final iteration writes HI, LO, o_result, o_zf and o_dz at edge E0+WIDTH, with o_valid=1 in the following cycle; the FSM returns to IDLE at that edge.
REQ-023 o_ready=1 in the o_valid cycle of a multi-cycle op; back-to-back acceptance is allowed there.
REQ-024 i_valid while o_ready=0 is ignored (no queueing); i_op1, i_op2 and i_control changes during MUL/DIV do not affect the result.
REQ-025 HI/LO change only at MULTU/DIVU completion or reset; they stay valid across any number of later single-cycle ops.
REQ-026 o_valid is never high for two consecutive cycles from a single request; without acceptance, o_valid=0 next cycle and o_result holds its last value.

Reset
REQ-027 At an edge with i_rst_n=0: state=IDLE, iteration counter=0, HI=0, LO=0, o_result=0, o_zf=1, o_valid=0, o_dz=0; o_ready=1 from the next cycle.
REQ-028 Reset during MUL/DIV aborts the operation: HI/LO cleared, no o_valid pulse for the aborted op.
REQ-029 i_valid is ignored at any edge where i_rst_n=0.

Verification (WIDTH=32)
REQ-030 ADD 0xFFFFFFFF+1 -> next cycle o_valid=1, o_result=0, o_zf=1; SUB 5-7 -> 0xFFFFFFFE, o_zf=0.
REQ-031 SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0; NOR 0,0 -> 0xFFFFFFFF.
REQ-032 MULTU 0xFFFFFFFF*0xFFFFFFFF -> o_ready low 32 cycles, o_valid one cycle, then o_result=LO=0x00000001; MFHI -> 0xFFFFFFFE.
REQ-033 DIVU 100/7 -> o_result=14, o_hi=2, o_dz=0; DIVU 9/0 -> o_result=0xFFFFFFFF, o_hi=9, o_dz=1.
REQ-034 During MULTU, pulse i_valid with ADD -> ignored, exactly one o_valid (MULTU); issue ADD in the MULTU o_valid cycle -> accepted, its o_valid one cycle later.
REQ-035 Assert i_rst_n=0 at iteration 10 of DIVU -> no o_valid, MFHI and MFLO return 0, o_ready=1 after release.
